boton_eventos: RTL and testbench
================================

BOTON_EVENTOS -- requirements
Module: boton_eventos

Interface
REQ-001 Parameter LONG_TIME, default 2000: consecutive high samples of btn_in that classify a press as long; legal range 2 and up.
REQ-002 Parameter REPEAT_TIME, default 250: high samples between successive repeat_pulse outputs while held; legal range 1 and up.
REQ-003 Parameter REPEAT_EN, default 1: 1 enables repeat_pulse generation; 0 forces repeat_pulse to 0.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_in  input  1  debounced button level; 1 means pressed. The block applies no further filtering.
REQ-007 short_pulse  output  1  one-cycle pulse: a press was released before it reached LONG_TIME samples.
REQ-008 long_pulse  output  1  one-cycle pulse: the press reached LONG_TIME consecutive high samples.
REQ-009 repeat_pulse  output  1  one-cycle pulse, issued periodically while a long press is held.
REQ-010 held  output  1  level output; 1 while the FSM is in PRESSED or HELD.

Function
REQ-011 The FSM SHALL have four states: LOCKOUT, IDLE, PRESSED and HELD.
REQ-012 Sample counter width SHALL be $clog2(max(LONG_TIME, REPEAT_TIME)+1) bits, unsigned, and the counter SHALL never wrap.
REQ-013 LOCKOUT:
- btn_in=0 -> go to IDLE.
- Otherwise stay in LOCKOUT and emit no pulses.
REQ-014 IDLE:
- btn_in=1 -> go to PRESSED and load counter=1.
- Otherwise stay in IDLE.
REQ-015 PRESSED, btn_in=0:
- short_pulse=1 on the next cycle; go to IDLE.
- This applies regardless of the counter value.
REQ-016 PRESSED, btn_in=1 and counter==LONG_TIME-1:
- long_pulse=1 on the next cycle; go to HELD and load counter=0.
- Otherwise increment the counter.
REQ-017 HELD, btn_in=0: go to IDLE and emit no pulse.
REQ-018 HELD, btn_in=1 and counter==REPEAT_TIME-1: repeat_pulse=REPEAT_EN and counter=0; otherwise increment the counter.
REQ-019 All outputs SHALL be registered. Each pulse is high for exactly one cycle, in the cycle following the edge that sampled the triggering btn_in value.
REQ-020 At most one of short_pulse, long_pulse and repeat_pulse SHALL be high in any cycle.
REQ-021 A release sampled on the same edge the threshold would be reached SHALL take priority:
- In PRESSED it produces short_pulse, not long_pulse.
- In HELD it produces no repeat_pulse.
REQ-022 Exactly one of short_pulse or long_pulse SHALL be produced per press cycle (IDLE back to IDLE).
REQ-023 held SHALL follow the registered state: 1 from the cycle after the press edge until the cycle after the release edge.

Reset
REQ-024 rst=1 sampled on an edge SHALL force the following values on the next cycle, overriding all other conditions:
- state=LOCKOUT
- counter=0
- short_pulse=0, long_pulse=0, repeat_pulse=0
- held=0
REQ-025 A reset asserted mid-press SHALL discard that press without any pulse. A new press is recognized only after btn_in=0 has been sampled post-reset.
REQ-026 With btn_in held high through reset release, no pulse SHALL be emitted until btn_in falls and rises again.

Structure
REQ-027 State encoding constants (2-bit: LOCKOUT, IDLE, PRESSED, HELD) SHALL live in the shared button package, so that display and game logic can decode them for debug.
REQ-028 The block SHALL be a single module with no submodules; counter and FSM are inline.
REQ-029 One instance SHALL be used per debounced button.

Verification (LONG_TIME=10, REPEAT_TIME=4, REPEAT_EN=1 unless stated)
REQ-030 rst high 2 cycles with btn_in=1, then btn_in=1 for 20 cycles -> no pulses and held=0; then btn_in=0 for 1 cycle and 1 for 3 cycles -> no pulses until the 0-then-1 sequence is seen, then short_pulse once, 1 cycle after release is sampled.
REQ-031 btn_in high for 9 samples, then low -> exactly one short_pulse; long_pulse never asserted; held=1 for 9 cycles.
REQ-032 btn_in high for exactly 10 samples, then low -> long_pulse one cycle after the 10th sample; no short_pulse; no repeat_pulse.
REQ-033 btn_in high for 20 samples -> long_pulse after sample 10; repeat_pulse after samples 14 and 18; release then yields no further pulses. The same run with REPEAT_EN=0 -> long_pulse only.
REQ-034 btn_in high for 6 samples, rst for 1 cycle, btn_in stays high for 10 more samples -> zero pulses and held=0 after reset; a subsequent press cycle behaves normally.
REQ-035 A checker on every cycle of all scenarios SHALL verify:
- pulse mutual exclusion
- one-cycle pulse width
- exactly one short_pulse or long_pulse per completed press

Source files
------------

// File: rtl/boton_eventos_pkg.sv
// Shared button types: FSM state encoding visible to display/game logic for debug decode,
// plus the sizing helper for the sample counter.
// Pure declarations, no latency, no flow control.
package boton_eventos_pkg;

  // 2-bit state encoding, fixed so other blocks can decode a probed state value.
  typedef enum logic [1:0] {
    ST_LOCKOUT = 2'd0,  // waiting for btn_in=0 after reset; ignores a held button
    ST_IDLE    = 2'd1,  // armed, waiting for a press
    ST_PRESSED = 2'd2,  // press in progress, not yet long
    ST_HELD    = 2'd3   // long press reached, generating repeats
  } btn_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter must hold the largest threshold without wrapping.
  function automatic int cnt_width(input int long_t, input int repeat_t);
    return $clog2(max_int(long_t, repeat_t) + 1);
  endfunction

endpackage

// File: rtl/boton_eventos_if.sv
// Button event bus: one debounced level in, three event pulses and a held level out.
// All outputs registered in the slave; pulses last exactly one cycle.
// No backpressure: events are fire-and-forget pulses the consumer must sample every cycle.
//
// Signals:
//   btn_in        debounced button level, 1 = pressed
//   short_pulse   press released before the long threshold
//   long_pulse    press reached the long threshold
//   repeat_pulse  periodic pulse while a long press is held
//   held          1 while a press is being tracked (PRESSED or HELD)
interface boton_eventos_if;
  logic btn_in;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  // Button side / event consumer.
  modport master (
    output btn_in,
    input  short_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held
  );

  // Event generator.
  modport slave (
    input  btn_in,
    output short_pulse,
    output long_pulse,
    output repeat_pulse,
    output held
  );
endinterface

// File: rtl/boton_eventos.sv
// Classifies a debounced button into short/long/repeat event pulses plus a held level.
// Latency: every output is registered, one cycle after the edge that sampled btn_in.
// No backpressure: pulses are single-cycle and never stall; one instance per button.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset; forces LOCKOUT so a press in flight is discarded
//   bus  boton_eventos_if.slave (btn_in in; short/long/repeat pulses and held out)
module boton_eventos
  import boton_eventos_pkg::*;
#(
  parameter int LONG_TIME   = 2000,  // high samples for a long press, >= 2
  parameter int REPEAT_TIME = 250,   // high samples between repeats, >= 1
  parameter int REPEAT_EN   = 1      // 0 suppresses repeat_pulse
) (
  input  logic            clk,
  input  logic            rst,
  boton_eventos_if.slave  bus
);

  localparam int CW = cnt_width(LONG_TIME, REPEAT_TIME);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TIME - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TIME - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic          REPEAT_ON   = (REPEAT_EN != 0);

  btn_state_t      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            short_nxt;
  logic            long_nxt;
  logic            repeat_nxt;
  logic            held_nxt;

  // Next-state, counter and pulse decode. Release is tested before any
  // threshold so a release on the threshold edge wins (short in PRESSED,
  // nothing in HELD). The counter only ever counts up to LONG_LAST or
  // REPEAT_LAST before reloading, so it never wraps.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;

    case (state)
      ST_LOCKOUT: begin
        // A button held through reset must be released before it can count.
        if (!bus.btn_in) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (bus.btn_in) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = CNT_ONE;   // this edge is the first high sample
        end
      end

      ST_PRESSED: begin
        if (!bus.btn_in) begin
          short_nxt = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end

      ST_HELD: begin
        if (!bus.btn_in) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_LAST) begin
          repeat_nxt = REPEAT_ON;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt    = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = ST_LOCKOUT;
        cnt_nxt   = '0;
      end
    endcase

    // held is registered alongside the state so it tracks the state register exactly.
    held_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_HELD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_LOCKOUT;
      cnt              <= '0;
      bus.short_pulse  <= 1'b0;
      bus.long_pulse   <= 1'b0;
      bus.repeat_pulse <= 1'b0;
      bus.held         <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      bus.short_pulse  <= short_nxt;
      bus.long_pulse   <= long_nxt;
      bus.repeat_pulse <= repeat_nxt;
      bus.held         <= held_nxt;
    end
  end

endmodule

// File: tb/tb_boton_eventos.sv
// Testbench for boton_eventos: two instances (repeats on / off) share one button.
// Directed vector table for the corner cases, then randomized presses against a
// run-length reference model; protocol properties checked on every cycle.
module tb_boton_eventos;

  localparam int L = 10;
  localparam int R = 4;

  logic clk;
  logic rst;
  logic btn;

  boton_eventos_if bus ();
  boton_eventos_if bus_nr ();

  assign bus.btn_in    = btn;
  assign bus_nr.btn_in = btn;

  boton_eventos #(.LONG_TIME(L), .REPEAT_TIME(R), .REPEAT_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  boton_eventos #(.LONG_TIME(L), .REPEAT_TIME(R), .REPEAT_EN(0)) dut_nr (
    .clk (clk),
    .rst (rst),
    .bus (bus_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected/actual vectors are packed {short, long, repeat, held}.
  typedef struct {
    logic       r;
    logic       b;
    logic [3:0] exp;
  } vec_t;

  vec_t tab[$];

  // Reference model: a press is a run of consecutive high samples, counted only
  // once the button has been seen low since the last reset.
  bit m_armed = 1'b0;
  int m_run   = 0;

  // Protocol tracking for the repeat-enabled instance.
  logic       held_prev   = 1'b0;
  logic [2:0] pulses_prev = 3'b000;
  int         press_evts  = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {s,l,r,h}=%b expected %b", name, act, exp);
  endtask

  task automatic check_bit(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [3:0] model_step(input logic r, input logic b);
    logic [3:0] e;
    e = 4'b0000;
    if (r) begin
      m_armed = 1'b0;
      m_run   = 0;
    end else if (!m_armed) begin
      if (!b) m_armed = 1'b1;
    end else if (b) begin
      m_run++;
      e[2] = (m_run == L);
      e[1] = (m_run > L) && (((m_run - L) % R) == 0);
      e[0] = 1'b1;
    end else begin
      e[3]  = (m_run > 0) && (m_run < L);
      m_run = 0;
    end
    return e;
  endfunction

  // One clock: drive, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic b, input bit use_tab,
                      input logic [3:0] tab_exp, input string name);
    logic [3:0] m_exp, exp, act, act_nr;
    logic [2:0] pulses;
    rst = r;
    btn = b;
    @(posedge clk);
    m_exp = model_step(r, b);
    #1;
    exp    = use_tab ? tab_exp : m_exp;
    act    = {bus.short_pulse, bus.long_pulse, bus.repeat_pulse, bus.held};
    act_nr = {bus_nr.short_pulse, bus_nr.long_pulse, bus_nr.repeat_pulse, bus_nr.held};
    check(name, act, exp);
    check({name, "_norep"}, act_nr, exp & 4'b1101);

    pulses = act[3:1];
    check_bit({name, "_mutex"}, $countones(pulses) <= 1, $countones(pulses), 1);
    check_bit({name, "_width"}, (pulses & pulses_prev) == 3'b000,
              int'(pulses & pulses_prev), 0);

    // Short arrives the cycle after release, long while held: both follow a held=1 cycle.
    if (held_prev) press_evts += int'(act[3]) + int'(act[2]);
    if (r) begin
      press_evts = 0;
    end else if (held_prev && !act[0]) begin
      check_bit({name, "_one_evt"}, press_evts == 1, press_evts, 1);
      press_evts = 0;
    end
    held_prev   = act[0];
    pulses_prev = pulses;
  endtask

  task automatic add(input logic r, input logic b, input int n, input logic [3:0] e);
    vec_t v;
    v.r   = r;
    v.b   = b;
    v.exp = e;
    for (int k = 0; k < n; k++) tab.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b1;

    // Reset with button held, stays held: locked out until a 0 then 1.
    add(1, 1, 2,  4'b0000);
    add(0, 1, 20, 4'b0000);
    add(0, 0, 1,  4'b0000);
    add(0, 1, 3,  4'b0001);
    add(0, 0, 1,  4'b1000);
    add(0, 0, 1,  4'b0000);
    // 9 samples then release on the long-threshold edge: short wins.
    add(0, 1, 9,  4'b0001);
    add(0, 0, 1,  4'b1000);
    add(0, 0, 1,  4'b0000);
    // Exactly 10 samples: long, no short on release.
    add(0, 1, 9,  4'b0001);
    add(0, 1, 1,  4'b0101);
    add(0, 0, 2,  4'b0000);
    // 20 samples: long after 10, repeats after 14 and 18.
    add(0, 1, 9,  4'b0001);
    add(0, 1, 1,  4'b0101);
    add(0, 1, 3,  4'b0001);
    add(0, 1, 1,  4'b0011);
    add(0, 1, 3,  4'b0001);
    add(0, 1, 1,  4'b0011);
    add(0, 1, 2,  4'b0001);
    add(0, 0, 2,  4'b0000);
    // Release on the repeat edge (sample 14): no repeat.
    add(0, 1, 9,  4'b0001);
    add(0, 1, 1,  4'b0101);
    add(0, 1, 3,  4'b0001);
    add(0, 0, 2,  4'b0000);
    // Reset mid-press with button still held: press discarded, then a normal press.
    add(0, 1, 6,  4'b0001);
    add(1, 1, 1,  4'b0000);
    add(0, 1, 10, 4'b0000);
    add(0, 0, 1,  4'b0000);
    add(0, 1, 3,  4'b0001);
    add(0, 0, 1,  4'b1000);
    add(0, 0, 1,  4'b0000);

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].r, tab[i].b, 1'b1, tab[i].exp, $sformatf("vec%0d", i));
    end

    // Randomized presses of assorted lengths with occasional resets.
    begin
      logic lvl;
      int   len;
      lvl = 1'b0;
      for (int seg = 0; seg < 150; seg++) begin
        if ($urandom_range(0, 19) == 0) begin
          len = $urandom_range(1, 2);
          for (int k = 0; k < len; k++)
            step(1'b1, logic'($urandom_range(0, 1)), 1'b0, 4'b0000, $sformatf("rnd%0d_rst", seg));
        end
        lvl = ~lvl;
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 12);
        for (int k = 0; k < len; k++)
          step(1'b0, lvl, 1'b0, 4'b0000, $sformatf("rnd%0d_%0d", seg, k));
      end
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 4'b0000, "drain");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
